// File: rtl/tis_pkg.sv
// Shared definitions for the TIS output-stream checker: word geometry,
// checker state encoding and the "no mismatch yet" marker.
package tis_pkg;

  localparam int unsigned WORD_W  = 11;
  localparam int unsigned MAX_LEN = 39;

  localparam logic [5:0] NO_MISMATCH = 6'd63;
  localparam logic [5:0] COUNT_MAX   = 6'd63;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/outstream_check.sv
// Consumes values from a node output port with a one-cycle acknowledge,
// records them and checks them against an expected stream of fixed length.
module outstream_check #(
  parameter int unsigned WORD_W  = tis_pkg::WORD_W,
  parameter int unsigned MAX_LEN = tis_pkg::MAX_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wvalid,
  input  logic signed [WORD_W-1:0] wdata,
  input  logic [5:0]               length,
  input  logic signed [WORD_W-1:0] expected [0:MAX_LEN-1],
  output logic                     rready,
  output logic [5:0]               count,
  output logic signed [WORD_W-1:0] captured [0:MAX_LEN-1],
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [5:0]               mismatch_pos,
  output logic                     overflow
);

  import tis_pkg::*;

  localparam logic [5:0] LAST_SLOT = 6'(MAX_LEN - 1);

  state_t     state, next_state;
  logic       accept;
  logic [5:0] last_idx;
  logic [5:0] wr_idx;
  logic       in_range;

  // Never accept while acknowledging, so rready cannot be high two cycles running.
  assign accept   = wvalid && !rready;
  assign last_idx = length - 6'd1;
  assign in_range = (count <= LAST_SLOT);
  assign wr_idx   = in_range ? count : LAST_SLOT;
  assign pass     = done && !fail;

  // Reset state follows length, which is held static while out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (length != 6'd0) ? RUN : DONE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (accept && (count == last_idx)) next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rready       <= 1'b0;
      count        <= '0;
      done         <= (length == 6'd0);
      fail         <= 1'b0;
      overflow     <= 1'b0;
      mismatch_pos <= NO_MISMATCH;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        captured[i] <= '0;
      end
    end else begin
      rready <= accept;
      if (accept) begin
        if (count != COUNT_MAX) count <= count + 6'd1;
        if (state == RUN) begin
          if (in_range) begin
            captured[wr_idx] <= wdata;
            if ((wdata != expected[wr_idx]) && (mismatch_pos == NO_MISMATCH)) begin
              fail         <= 1'b1;
              mismatch_pos <= count;
            end
          end
          if (count == last_idx) done <= 1'b1;
        end else begin
          overflow <= 1'b1;
          fail     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_outstream_check.sv
// Directed bench for outstream_check: nominal streams, mismatch, overflow,
// zero-length, full-length and mid-stream reset scenarios.
module tb_outstream_check;

  localparam int W = 11;
  localparam int L = 39;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wvalid = 1'b0;
  logic signed [W-1:0] wdata = '0;
  logic [5:0]          length = 6'd0;
  logic signed [W-1:0] exp_vals [0:L-1];
  logic                rready;
  logic [5:0]          count;
  logic signed [W-1:0] captured [0:L-1];
  logic                done, pass, fail, overflow;
  logic [5:0]          mismatch_pos;

  int n_checks = 0;
  int n_fails  = 0;
  int pulse_cnt = 0;
  int adj_cnt = 0;
  int last_gap = 0;
  int last_pulse = 0;
  int cyc = 0;
  logic prev_r = 1'b0;

  outstream_check #(.WORD_W(W), .MAX_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .wvalid(wvalid), .wdata(wdata),
    .length(length), .expected(exp_vals), .rready(rready), .count(count),
    .captured(captured), .done(done), .pass(pass), .fail(fail),
    .mismatch_pos(mismatch_pos), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (rready) begin
      if (prev_r) adj_cnt++;
      pulse_cnt++;
      last_gap   = cyc - last_pulse;
      last_pulse = cyc;
    end
    prev_r = rready;
    cyc++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [5:0] len);
    @(negedge clk);
    wvalid = 1'b0;
    length = len;
    rst_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    pulse_cnt = 0;
    adj_cnt   = 0;
  endtask

  // Offers one value and holds it until rready is observed (bounded).
  task automatic send(input logic signed [W-1:0] v);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    wvalid = 1'b1;
    wdata  = v;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rready) begin
        seen = 1'b1;
        break;
      end
    end
    check("rready_seen", seen, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    wvalid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < L; i++) exp_vals[i] = '0;

    // Nominal three-value stream
    exp_vals[0] = 11'sd5; exp_vals[1] = -11'sd2; exp_vals[2] = 11'sd999;
    do_reset(6'd3);
    check("rst_rready", rready, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_mpos", mismatch_pos, 63);
    check("rst_cap0", captured[0], 0);
    send(11'sd5); send(-11'sd2); send(11'sd999);
    idle();
    check("t1_pulses", pulse_cnt, 3);
    check("t1_gap", last_gap, 2);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_mpos", mismatch_pos, 63);
    check("t1_cap1", captured[1], -2);

    // Mismatch at index 1, stream still completes
    exp_vals[0] = 11'sd1; exp_vals[1] = 11'sd2; exp_vals[2] = 11'sd3;
    do_reset(6'd3);
    send(11'sd1); send(11'sd7);
    check("t2_done_early", done, 0);
    send(11'sd4);
    idle();
    check("t2_fail", fail, 1);
    check("t2_mpos", mismatch_pos, 1);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_cap0", captured[0], 1);
    check("t2_cap1", captured[1], 7);
    check("t2_cap2", captured[2], 4);

    // Overflow after done
    exp_vals[0] = 11'sd0; exp_vals[1] = 11'sd0; exp_vals[2] = 11'sd0;
    do_reset(6'd2);
    send(11'sd0); send(11'sd0);
    check("t3_done", done, 1);
    check("t3_pass_pre", pass, 1);
    send(11'sd12);
    idle();
    check("t3_overflow", overflow, 1);
    check("t3_pass", pass, 0);
    check("t3_count", count, 3);
    check("t3_cap2", captured[2], 0);
    check("t3_pulses", pulse_cnt, 3);

    // Zero-length stream
    do_reset(6'd0);
    check("t4_done", done, 1);
    check("t4_pass", pass, 1);
    send(-11'sd999);
    idle();
    check("t4_overflow", overflow, 1);
    check("t4_fail", fail, 1);
    check("t4_count", count, 1);
    check("t4_cap0", captured[0], 0);

    // Full-length stream, wvalid held high throughout
    for (int i = 0; i < L; i++) exp_vals[i] = (i % 2 == 0) ? -11'sd999 : 11'sd999;
    do_reset(6'd39);
    for (int i = 0; i < L; i++) send((i % 2 == 0) ? -11'sd999 : 11'sd999);
    idle();
    check("t5_pulses", pulse_cnt, 39);
    check("t5_adjacent", adj_cnt, 0);
    check("t5_pass", pass, 1);
    check("t5_count", count, 39);
    check("t5_cap38", captured[38], -999);
    check("t5_cap37", captured[37], 999);

    // Mid-stream asynchronous reset, then full rerun
    exp_vals[0] = 11'sd10; exp_vals[1] = 11'sd20; exp_vals[2] = 11'sd30; exp_vals[3] = 11'sd40;
    do_reset(6'd4);
    send(11'sd10); send(11'sd99);
    check("t6_fail_pre", fail, 1);
    #2;
    rst_n  = 1'b0;
    wvalid = 1'b0;
    #1;
    check("t6_rst_rready", rready, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_fail", fail, 0);
    check("t6_rst_mpos", mismatch_pos, 63);
    check("t6_rst_done", done, 0);
    check("t6_rst_cap1", captured[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(11'sd10); send(11'sd20); send(11'sd30); send(11'sd40);
    idle();
    check("t6_pass", pass, 1);
    check("t6_count", count, 4);
    check("t6_cap3", captured[3], 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
